// File: rtl/dbus_ram_pkg.sv
// rtl/dbus_ram_pkg.sv - shared types, strobe encodings and alignment helper for the DBus RAM responder
package dbus_ram_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dbus_state_t;

    localparam logic [3:0] DBUS_STROBE_B = 4'h1;
    localparam logic [3:0] DBUS_STROBE_H = 4'h3;
    localparam logic [3:0] DBUS_STROBE_W = 4'hF;

    // True when the strobe, shifted to the byte offset, spills into the next word.
    function automatic logic dbus_misaligned(input logic [1:0] off, input logic [3:0] strobe);
        logic [7:0] lanes;
        lanes = {4'b0000, strobe} << off;
        return |lanes[7:4];
    endfunction

endpackage

// File: rtl/dbus_ram_array.sv
// rtl/dbus_ram_array.sv - single-port word RAM with byte-enable write and registered read
module dbus_ram_array
    import dbus_ram_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  word_t         wr_data,
    output word_t         rd_data
);

    word_t mem [DEPTH];
    word_t rd_data_q;

    // A write cycle leaves the read register untouched so it keeps the last read word.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
            if (we == 4'b0000) begin
                rd_data_q <= mem[addr];
            end
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/dbus_ram.sv
// rtl/dbus_ram.sv - DBus data-memory responder with wait states, lane alignment and error reporting
module dbus_ram
    import dbus_ram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int          SIZE_BYTES  = 4096,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dbus_rd_en,
    input  logic        dbus_wr_en,
    input  logic [31:0] dbus_addr,
    input  logic [31:0] dbus_wr_data,
    input  logic [3:0]  dbus_wr_strobe,
    output logic [31:0] dbus_rd_data,
    output logic        dbus_wait,
    output logic        dbus_err
);

    localparam int          DEPTH    = SIZE_BYTES / 4;
    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] WIN_MASK = ~(32'(SIZE_BYTES) - 32'd1);
    localparam logic [3:0]  CNT_INIT = 4'(WAIT_STATES - 1);

    dbus_state_t   state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] widx_q, widx_d;
    logic [1:0]    off_q, off_d;
    logic          wr_q, wr_d;
    word_t         wdata_q, wdata_d;
    logic [3:0]    wmask_q, wmask_d;

    logic          req;
    logic [1:0]    off;
    logic [7:0]    lanes;
    logic          in_range;
    logic          bad;
    logic [AW-1:0] widx_in;

    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    word_t         ram_q;

    assign req      = dbus_rd_en | dbus_wr_en;
    assign off      = dbus_addr[1:0];
    assign lanes    = {4'b0000, dbus_wr_strobe} << off;
    assign in_range = (dbus_addr & WIN_MASK) == BASE_ADDR;
    assign bad      = !in_range || dbus_misaligned(off, dbus_wr_strobe) || (dbus_rd_en && dbus_wr_en);
    assign widx_in  = (DEPTH > 1) ? dbus_addr[AW+1:2] : '0;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        widx_d       = widx_q;
        off_d        = off_q;
        wr_d         = wr_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        ram_en       = 1'b0;
        ram_we       = 4'b0000;
        ram_addr     = widx_q;
        dbus_rd_data = 32'h0;
        dbus_wait    = 1'b0;
        dbus_err     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req && bad) begin
                    dbus_err = 1'b1;
                end else if (req) begin
                    dbus_wait = 1'b1;
                    widx_d    = widx_in;
                    off_d     = off;
                    wr_d      = dbus_wr_en;
                    wdata_d   = dbus_wr_data << {off, 3'b000};
                    wmask_d   = lanes[3:0];
                    ram_en    = 1'b1;
                    ram_addr  = widx_in;
                    cnt_d     = CNT_INIT;
                    state_d   = (CNT_INIT == 4'd0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (!req) begin
                    state_d = IDLE;
                end else begin
                    dbus_wait = 1'b1;
                    cnt_d     = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                // A dropped request here is a flush: nothing is committed or returned.
                if (req) begin
                    if (wr_q) begin
                        ram_en = 1'b1;
                        ram_we = wmask_q;
                    end else begin
                        dbus_rd_data = ram_q >> {off_q, 3'b000};
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (!rst_n) begin
            dbus_rd_data = 32'h0;
            dbus_wait    = 1'b0;
            dbus_err     = 1'b0;
            ram_en       = 1'b0;
            ram_we       = 4'b0000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            widx_q  <= '0;
            off_q   <= 2'd0;
            wr_q    <= 1'b0;
            wdata_q <= 32'h0;
            wmask_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            widx_q  <= widx_d;
            off_q   <= off_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
        end
    end

    dbus_ram_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .en      (ram_en),
        .we      (ram_we),
        .addr    (ram_addr),
        .wr_data (wdata_q),
        .rd_data (ram_q)
    );

endmodule

// File: tb/tb_dbus_ram.sv
// tb/tb_dbus_ram.sv - self-checking bench for dbus_ram with one-wait and three-wait instances
module tb_dbus_ram;

    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam int          SIZE = 4096;

    logic        clk;
    logic        rst_n;
    logic        rd_en [2];
    logic        wr_en [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [3:0]  strb  [2];
    logic [31:0] rdata [2];
    logic        wt    [2];
    logic        err   [2];

    int nchk = 0;
    int nerr = 0;

    logic [7:0] mdl [2][SIZE];

    dbus_ram #(.BASE_ADDR(BASE), .SIZE_BYTES(SIZE), .WAIT_STATES(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .dbus_rd_en(rd_en[0]), .dbus_wr_en(wr_en[0]),
        .dbus_addr(addr[0]), .dbus_wr_data(wdata[0]), .dbus_wr_strobe(strb[0]),
        .dbus_rd_data(rdata[0]), .dbus_wait(wt[0]), .dbus_err(err[0])
    );

    dbus_ram #(.BASE_ADDR(BASE), .SIZE_BYTES(SIZE), .WAIT_STATES(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .dbus_rd_en(rd_en[1]), .dbus_wr_en(wr_en[1]),
        .dbus_addr(addr[1]), .dbus_wr_data(wdata[1]), .dbus_wr_strobe(strb[1]),
        .dbus_rd_data(rdata[1]), .dbus_wait(wt[1]), .dbus_err(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int u, input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s);
        rd_en[u] = rd;
        wr_en[u] = wr;
        addr[u]  = a;
        wdata[u] = d;
        strb[u]  = s;
    endtask

    function automatic logic model_bad(input logic rd, input logic wr, input logic [31:0] a,
                                       input logic [3:0] s);
        logic [63:0] a64;
        int          top;
        a64 = {32'h0, a};
        top = 0;
        for (int i = 0; i < 4; i++) if (s[i]) top = i + 1;
        return (a64 < 64'(BASE)) || (a64 >= 64'(BASE) + 64'(SIZE)) ||
               (int'(a[1:0]) + top > 4) || (rd && wr);
    endfunction

    function automatic logic [31:0] model_rd(input int u, input logic [31:0] a);
        int          base;
        int          off;
        logic [31:0] r;
        off  = int'(a[1:0]);
        base = int'(a - BASE) - off;
        r    = 32'h0;
        for (int i = off; i < 4; i++) r = r | (32'(mdl[u][base + i]) << (8 * (i - off)));
        return r;
    endfunction

    // Drives one request and follows it to completion; leaves the request asserted.
    task automatic txn(input int u, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       output logic e, output int waits, output logic [31:0] r);
        bit done;
        set_in(u, rd, wr, a, d, s);
        waits = 0;
        e     = 1'b0;
        r     = 32'h0;
        done  = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (wt[u]) begin
                waits++;
                step();
            end else begin
                e    = err[u];
                r    = rdata[u];
                done = 1'b1;
            end
        end
        if (!done) chk("txn_timeout", 32'(waits), 32'd0);
        step();
        if (!model_bad(rd, wr, a, s) && wr) begin
            for (int i = 0; i < 4; i++)
                if (s[i]) mdl[u][int'(a - BASE) + i] = d[8*i +: 8];
        end
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic        exp_err;
        int          exp_waits;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [14];

    initial begin
        logic        e;
        int          w;
        logic [31:0] r;
        logic [31:0] old_w;
        logic [31:0] new_w;
        logic [31:0] ea;
        logic [3:0]  s;
        logic        rd;
        logic        wr;
        logic        exp_bad;
        logic [31:0] exp_r;
        int          kind;
        localparam logic [31:0] A = BASE + 32'h20;

        for (int u = 0; u < 2; u++) set_in(u, 0, 0, 0, 0, 0);
        rst_n = 1'b0;

        // Requests asserted under reset must not produce any response.
        set_in(0, 1, 0, 32'h0001_0010, 0, 4'hF);
        set_in(1, 1, 0, 32'h0000_0000, 0, 4'hF);
        repeat (2) @(negedge clk);
        chk("reset_wait", 32'(wt[0]), 32'd0);
        chk("reset_err", 32'(err[1]), 32'd0);
        chk("reset_rdata", rdata[0], 32'h0);
        for (int u = 0; u < 2; u++) set_in(u, 0, 0, 0, 0, 0);
        step();
        rst_n = 1'b1;
        step();

        tbl[0]  = '{1'b0, 1'b1, 32'h0001_0010, 32'hDEADBEEF, 4'hF, 1'b0, 1, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 32'h0001_0010, 32'h0,        4'hF, 1'b0, 1, 32'hDEADBEEF};
        tbl[2]  = '{1'b0, 1'b1, 32'h0001_0013, 32'h0000_00AA, 4'h1, 1'b0, 1, 32'h0};
        tbl[3]  = '{1'b1, 1'b0, 32'h0001_0013, 32'h0,        4'h1, 1'b0, 1, 32'h0000_00AA};
        tbl[4]  = '{1'b1, 1'b0, 32'h0001_0010, 32'h0,        4'hF, 1'b0, 1, 32'hAAADBEEF};
        tbl[5]  = '{1'b0, 1'b1, 32'h0001_0013, 32'h0000_5555, 4'h3, 1'b1, 0, 32'h0};
        tbl[6]  = '{1'b1, 1'b0, 32'h0000_FFFC, 32'h0,        4'hF, 1'b1, 0, 32'h0};
        tbl[7]  = '{1'b1, 1'b1, 32'h0001_0010, 32'h1111_1111, 4'hF, 1'b1, 0, 32'h0};
        tbl[8]  = '{1'b1, 1'b0, 32'h0001_0010, 32'h0,        4'hF, 1'b0, 1, 32'hAAADBEEF};
        tbl[9]  = '{1'b1, 1'b0, 32'h0001_1000, 32'h0,        4'h1, 1'b1, 0, 32'h0};
        tbl[10] = '{1'b0, 1'b1, 32'h0001_0FFC, 32'h1234_5678, 4'hF, 1'b0, 1, 32'h0};
        tbl[11] = '{1'b1, 1'b0, 32'h0001_0FFE, 32'h0,        4'h3, 1'b0, 1, 32'h0000_1234};
        tbl[12] = '{1'b0, 1'b1, 32'h0001_0012, 32'h0000_55CC, 4'h3, 1'b0, 1, 32'h0};
        tbl[13] = '{1'b1, 1'b0, 32'h0001_0010, 32'h0,        4'hF, 1'b0, 1, 32'h55CCBEEF};

        for (int i = 0; i < 14; i++) begin
            txn(0, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].s, e, w, r);
            chk($sformatf("vec%0d_err", i), 32'(e), 32'(tbl[i].exp_err));
            chk($sformatf("vec%0d_waits", i), 32'(w), 32'(tbl[i].exp_waits));
            chk($sformatf("vec%0d_rdata", i), r, tbl[i].exp_rd);
        end
        set_in(0, 0, 0, 0, 0, 0);
        step();

        for (int u = 0; u < 2; u++) begin
            for (int k = 0; k < 64; k++) txn(u, 0, 1, BASE + 32'(4 * k), $urandom, 4'hF, e, w, r);
            set_in(u, 0, 0, 0, 0, 0);
            step();
        end

        for (int u = 0; u < 2; u++) begin
            for (int n = 0; n < 120; n++) begin
                kind = int'($urandom_range(0, 9));
                case ($urandom_range(0, 2))
                    0:       s = 4'h1;
                    1:       s = 4'h3;
                    default: s = 4'hF;
                endcase
                rd = $urandom_range(0, 1) == 1;
                wr = !rd;
                if (kind == 0) begin
                    if ($urandom_range(0, 1) == 1) ea = BASE - 32'(4 * $urandom_range(1, 4));
                    else ea = BASE + 32'(SIZE) + 32'($urandom_range(0, 15));
                end else begin
                    ea = BASE + 32'($urandom_range(0, 255));
                    if (kind == 1) begin
                        rd = 1'b1;
                        wr = 1'b1;
                    end
                end
                exp_bad = model_bad(rd, wr, ea, s);
                exp_r   = (!exp_bad && rd) ? model_rd(u, ea) : 32'h0;
                txn(u, rd, wr, ea, $urandom, s, e, w, r);
                chk($sformatf("rnd%0d_%0d_err", u, n), 32'(e), 32'(exp_bad));
                chk($sformatf("rnd%0d_%0d_waits", u, n), 32'(w), exp_bad ? 32'd0 : 32'(u == 1 ? 3 : 1));
                chk($sformatf("rnd%0d_%0d_rdata", u, n), r, exp_r);
                if ($urandom_range(0, 3) == 0) begin
                    set_in(u, 0, 0, 0, 0, 0);
                    step();
                end
            end
            set_in(u, 0, 0, 0, 0, 0);
            step();
        end

        // Read abort after two wait cycles on the three-wait instance.
        old_w = model_rd(1, A);
        new_w = ~old_w;
        set_in(1, 1, 0, A, 0, 4'hF);
        @(negedge clk);
        chk("abort_rd_wait0", 32'(wt[1]), 32'd1);
        step();
        @(negedge clk);
        chk("abort_rd_wait1", 32'(wt[1]), 32'd1);
        step();
        set_in(1, 0, 0, 0, 0, 0);
        #1;
        chk("abort_rd_wait", 32'(wt[1]), 32'd0);
        chk("abort_rd_err", 32'(err[1]), 32'd0);
        chk("abort_rd_rdata", rdata[1], 32'h0);
        step();
        txn(1, 1, 0, A, 0, 4'hF, e, w, r);
        chk("post_abort_waits", 32'(w), 32'd3);
        chk("post_abort_rdata", r, old_w);
        set_in(1, 0, 0, 0, 0, 0);
        step();

        // Write aborted in BUSY.
        set_in(1, 0, 1, A, new_w, 4'hF);
        step();
        step();
        set_in(1, 0, 0, 0, 0, 0);
        #1;
        chk("abort_wr_busy_wait", 32'(wt[1]), 32'd0);
        step();
        txn(1, 1, 0, A, 0, 4'hF, e, w, r);
        chk("abort_wr_busy_word", r, old_w);
        set_in(1, 0, 0, 0, 0, 0);
        step();

        // Write aborted in its final cycle.
        set_in(1, 0, 1, A, new_w, 4'hF);
        step();
        step();
        step();
        set_in(1, 0, 0, 0, 0, 0);
        step();
        txn(1, 1, 0, A, 0, 4'hF, e, w, r);
        chk("abort_wr_done_word", r, old_w);
        set_in(1, 0, 0, 0, 0, 0);
        step();

        // Reset during the BUSY phase of a write.
        set_in(1, 0, 1, A, new_w, 4'hF);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_wait", 32'(wt[1]), 32'd0);
        chk("rst_mid_err", 32'(err[1]), 32'd0);
        set_in(1, 0, 0, 0, 0, 0);
        step();
        rst_n = 1'b1;
        step();
        txn(1, 1, 0, A, 0, 4'hF, e, w, r);
        chk("rst_mid_word", r, old_w);

        // Back-to-back write then read on the three-wait instance.
        txn(1, 0, 1, A, new_w, 4'hF, e, w, r);
        txn(1, 1, 0, A, 0, 4'hF, e, w, r);
        chk("b2b_err", 32'(e), 32'd0);
        chk("b2b_rdata", r, model_rd(1, A));
        chk("b2b_rdata_new", r, new_w);
        set_in(1, 0, 0, 0, 0, 0);
        step();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/dbus_ram.md
Name: dbus_ram

Overview:
- Data-memory responder at the far end of the core's DBus; services the load/store unit's read and write requests.
- Provides a byte-addressable, word-organised SRAM window with programmable wait states.
- Handles byte-lane alignment so that load data always returns in the low lanes.
- Signals bus errors for out-of-range, misaligned or conflicting requests.

Parameters:
- BASE_ADDR, 32'h0001_0000, byte address of first location; must be SIZE_BYTES-aligned.
- SIZE_BYTES, 4096, window size in bytes; power of two, at least 4.
- WAIT_STATES, 1, cycles dbus_wait is held for a good request; legal range 1..15.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- dbus_rd_en  in  1  read request.
- dbus_wr_en  in  1  write request.
- dbus_addr  in  32  byte address.
- dbus_wr_data  in  32  write data, lane 0 aligned.
- dbus_wr_strobe  in  4  lane mask relative to dbus_addr (1, 3 or F).
- dbus_rd_data  out  32  read data, addressed byte in [7:0].
- dbus_wait  out  1  transaction not yet complete.
- dbus_err  out  1  request aborted.

Behaviour:
- Reset: rst_n is asynchronous and active-low. While rst_n is low, FSM is IDLE and all outputs (dbus_rd_data, dbus_wait, dbus_err) are 0. Memory contents are not cleared.
- Request: req = dbus_rd_en | dbus_wr_en.
- Byte offset: off = dbus_addr[1:0].
- Lane mask: lanes = {4'b0, strobe} << off, 8 bits wide.
- Error conditions (bad), each checked combinationally in IDLE:
  - dbus_addr outside [BASE_ADDR, BASE_ADDR+SIZE_BYTES).
  - lanes[7:4] != 0, i.e. the access crosses a word boundary.
  - dbus_rd_en & dbus_wr_en both asserted.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - req & bad: dbus_err=1, dbus_wait=0 in the same cycle. No memory access, rd_data=0, stay IDLE.
  - req & !bad: dbus_wait=1. Latch word index, off, rd/wr type, shifted write data and shifted mask. Issue the synchronous RAM read at this edge. Load cnt=WAIT_STATES-1. Next state is DONE if cnt==0, else BUSY.
  - no req: all outputs 0.
- BUSY:
  - dbus_wait=1.
  - cnt decrements each cycle; at cnt==1, move to DONE.
- DONE (final cycle):
  - dbus_wait=0, dbus_err=0.
  - Read: dbus_rd_data = ram_q >> (8*off_latched), zero-filled above.
  - Write: at the closing edge, commit bytes whose latched mask bit is set; data = wr_data << (8*off). dbus_rd_data=0.
  - Next state is IDLE.
- Latency: a good transaction is WAIT_STATES+1 cycles long, with dbus_wait high for exactly WAIT_STATES cycles.
- Back-to-back: if req is asserted in the cycle after DONE, it is treated as a new transaction from IDLE. There are no idle bubbles beyond IDLE evaluation.
- Abort: if req drops while in BUSY or DONE (pipeline flush or exception), return to IDLE at the next edge. No write is committed and outputs go to 0 immediately.
- Initiator obligation: hold addr/data/strobe stable while dbus_wait=1. The responder uses its latched copies regardless.
- Reset mid-transaction: a pending write is discarded; the memory word is unchanged.
- Endianness: the responder has none; lane order is fixed little-endian and the initiator swaps.

Decomposition:
- lexington package:
  - dbus_state_t enum {IDLE, BUSY, DONE}.
  - DBUS_STROBE_B/H/W constants (4'h1/4'h3/4'hF).
  - Function dbus_misaligned(addr[1:0], strobe).
- rv32 package: existing word type reused.
- Sub-module dbus_ram_array: single-port synchronous RAM, depth SIZE_BYTES/4, 4-bit byte-enable write, registered read. Instantiated once.

Test Plan:
- WAIT_STATES=1, SW addr 0x0001_0010, data 0xDEADBEEF, strobe F: wait high 1 cycle. Then LW same address: wait 1 cycle, then rd_data=0xDEADBEEF, err=0.
- SB 0x0001_0013 with data 0x000000AA; LBU 0x0001_0013 returns 0x000000AA; LW 0x0001_0010 returns 0xAAADBEEF (other bytes unchanged).
- LH addr 0x0001_0013 (strobe 3) -> err=1, wait=0 the same cycle, no write. LW 0x0000_FFFC (below base) -> err=1.
- WAIT_STATES=3: LW -> wait high exactly 3 cycles. Drop rd_en after 2 cycles -> FSM IDLE next cycle, outputs 0. Abort a SW mid-wait -> target word unchanged.
- rd_en & wr_en together -> err=1. Assert rst_n low during BUSY of a SW -> outputs 0 immediately, and a later LW returns the old value.
- Back-to-back SW then LW to the same address with no idle cycle -> LW returns the newly written value.
